// File: rtl/removedor_pkg.sv
// Shared types and defaults for the trash-removal actuator sequencer.
// State encoding, default timing constants and the phase-timer width helper.
package removedor_pkg;

    localparam int unsigned T_BRACO_DEF  = 4;
    localparam int unsigned T_COLETA_DEF = 8;
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned MAX_TENT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ABAIXAR = 3'd1,
        COLETAR = 3'd2,
        ERGUER  = 3'd3,
        FIM     = 3'd4,
        LIBERA  = 3'd5
    } estado_t;

    // Timer must hold the longest phase reload value (duration - 1) without overflow.
    function automatic int unsigned tmr_w(input int unsigned t_braco, input int unsigned t_coleta);
        int unsigned m;
        m = (t_braco > t_coleta) ? t_braco : t_coleta;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/removedor_lixo_if.sv
// Request/status bundle between the sensor-decision stage and the removal sequencer.
interface removedor_lixo_if #(
    parameter int unsigned CNT_W = 8
);
    logic             remover;
    logic             under;
    logic             ocupado;
    logic             braco_desce;
    logic             succao;
    logic             concluido;
    logic             falha;
    logic [CNT_W-1:0] contagem;

    modport master (
        output remover, under,
        input  ocupado, braco_desce, succao, concluido, falha, contagem
    );

    modport slave (
        input  remover, under,
        output ocupado, braco_desce, succao, concluido, falha, contagem
    );
endinterface

// File: rtl/removedor_lixo_temporizador_fase.sv
// Loadable down-counter shared by every timed phase; zero flags the last cycle of a phase.
module temporizador_fase #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] valor,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/removedor_lixo.sv
// Trash-removal sequencer: lower arm, suction, raise arm, count the removed item.
// Optional suction re-check with bounded retries is enabled by defining REMOCAO_VERIFICA_EN.
module removedor_lixo
    import removedor_pkg::*;
#(
    parameter int unsigned T_BRACO  = T_BRACO_DEF,
    parameter int unsigned T_COLETA = T_COLETA_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MAX_TENT = MAX_TENT_DEF
) (
    input logic             clock,
    input logic             reset,
    removedor_lixo_if.slave io
);
    localparam int unsigned TMR_W = tmr_w(T_BRACO, T_COLETA);
    localparam logic [TMR_W-1:0] V_BRACO  = TMR_W'(T_BRACO - 1);
    localparam logic [TMR_W-1:0] V_COLETA = TMR_W'(T_COLETA - 1);

    estado_t            estado;
    estado_t            estado_nxt;
    logic               zero;
    logic               load_c;
    logic [TMR_W-1:0]   valor_c;
    logic               conta_c;

`ifdef REMOCAO_VERIFICA_EN
    localparam int unsigned TENT_W = (MAX_TENT < 1) ? 1 : $clog2(MAX_TENT + 1);

    logic [TENT_W-1:0]  tent;
    logic               pula;
    logic               retry_c;
    logic               falhou_c;
`else
    logic               unused_cfg;
    assign unused_cfg = ^{io.under, 32'(MAX_TENT)};
`endif

    temporizador_fase #(.W(TMR_W)) u_tmr (
        .clock (clock),
        .reset (reset),
        .load  (load_c),
        .valor (valor_c),
        .zero  (zero)
    );

    // Next state and phase-timer reload.
    always_comb begin
        estado_nxt = estado;
        load_c     = 1'b0;
        valor_c    = V_BRACO;
        conta_c    = 1'b1;
`ifdef REMOCAO_VERIFICA_EN
        retry_c    = 1'b0;
        falhou_c   = 1'b0;
        conta_c    = !pula;
`endif
        case (estado)
            IDLE: begin
                if (io.remover) begin
                    estado_nxt = ABAIXAR;
                    load_c     = 1'b1;
                    valor_c    = V_BRACO;
                end
            end
            ABAIXAR: begin
                if (zero) begin
                    estado_nxt = COLETAR;
                    load_c     = 1'b1;
                    valor_c    = V_COLETA;
                end
            end
            COLETAR: begin
                if (zero) begin
                    load_c = 1'b1;
`ifdef REMOCAO_VERIFICA_EN
                    if (io.under && (tent < TENT_W'(MAX_TENT))) begin
                        retry_c = 1'b1;
                        valor_c = V_COLETA;
                    end else begin
                        falhou_c   = io.under;
                        estado_nxt = ERGUER;
                        valor_c    = V_BRACO;
                    end
`else
                    estado_nxt = ERGUER;
                    valor_c    = V_BRACO;
`endif
                end
            end
            ERGUER: begin
                if (zero) begin
                    estado_nxt = FIM;
                end
            end
            FIM: begin
                estado_nxt = LIBERA;
            end
            LIBERA: begin
                if (!io.remover) begin
                    estado_nxt = IDLE;
                end
            end
            default: begin
                estado_nxt = IDLE;
            end
        endcase
    end

    // State plus outputs registered from the next state, so they track the state exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= IDLE;
            io.ocupado     <= 1'b0;
            io.braco_desce <= 1'b0;
            io.succao      <= 1'b0;
            io.concluido   <= 1'b0;
            io.falha       <= 1'b0;
            io.contagem    <= '0;
`ifdef REMOCAO_VERIFICA_EN
            tent           <= '0;
            pula           <= 1'b0;
`endif
        end else begin
            estado         <= estado_nxt;
            io.ocupado     <= (estado_nxt != IDLE);
            io.braco_desce <= (estado_nxt == ABAIXAR) || (estado_nxt == COLETAR);
            io.succao      <= (estado_nxt == COLETAR);
            io.concluido   <= (estado_nxt == FIM);

            // Saturating item count, taken on the FIM exit edge.
            if ((estado == FIM) && conta_c && (io.contagem != {CNT_W{1'b1}})) begin
                io.contagem <= io.contagem + CNT_W'(1);
            end

`ifdef REMOCAO_VERIFICA_EN
            if ((estado == IDLE) && (estado_nxt == ABAIXAR)) begin
                tent <= '0;
                pula <= 1'b0;
            end
            if (retry_c) begin
                tent <= tent + TENT_W'(1);
            end
            if (falhou_c) begin
                io.falha <= 1'b1;
                pula     <= 1'b1;
            end
`else
            io.falha <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_removedor_lixo.sv
// Directed bench for removedor_lixo: default instance plus a CNT_W=2 instance for saturation.
module tb_removedor_lixo;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    removedor_lixo_if #(.CNT_W(8)) bus ();
    removedor_lixo_if #(.CNT_W(2)) bus2 ();

    removedor_lixo #(.CNT_W(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .io    (bus.slave)
    );

    removedor_lixo #(.CNT_W(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .io    (bus2.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    int n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One request on the default instance; sample i is taken just after edge i (edge 0 = accept).
    task automatic run_seq(input int hold, input int under_until,
                           output int nb, output int ns, output int nc,
                           output int cat, output int no, output int cac);
        nb = 0; ns = 0; nc = 0; cat = -1; no = 0; cac = -1;
        bus.under   = (under_until > 0);
        bus.remover = 1'b1;
        for (int i = 0; i < hold + 50; i++) begin
            tick();
            if (bus.braco_desce) nb++;
            if (bus.succao) ns++;
            if (bus.ocupado) no++;
            if (bus.concluido) begin
                nc++;
                cat = i;
                cac = int'(bus.contagem);
            end
            if (i + 1 >= hold) bus.remover = 1'b0;
            bus.under = (i + 1 < under_until);
        end
        bus.under = 1'b0;
    endtask

    initial begin
        bus.remover  = 1'b1;
        bus.under    = 1'b0;
        bus2.remover = 1'b1;
        bus2.under   = 1'b0;

        // 1: reset held with a pending request
        tick();
        tick();
        check("rst_ocupado",   32'(bus.ocupado), 0);
        check("rst_braco",     32'(bus.braco_desce), 0);
        check("rst_succao",    32'(bus.succao), 0);
        check("rst_concluido", 32'(bus.concluido), 0);
        check("rst_falha",     32'(bus.falha), 0);
        check("rst_contagem",  32'(bus.contagem), 0);
        check("rst_contagem2", 32'(bus2.contagem), 0);
        reset        = 1'b0;
        bus.remover  = 1'b0;
        bus2.remover = 1'b0;
        tick();
        check("idle_ocupado", 32'(bus.ocupado), 0);

        // 2: single-cycle request
        run_seq(1, 0, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t2_braco_cycles", n_braco, 12);
        check("t2_succao_cycles", n_suc, 8);
        check("t2_conc_count", n_conc, 1);
        check("t2_conc_latency", conc_at, 16);
        check("t2_cnt_at_conc", cnt_at_conc, 0);
        check("t2_ocupado_cycles", n_ocup, 18);
        check("t2_contagem", 32'(bus.contagem), 1);

        // 3: request held high counts once, then a fresh request counts again
        run_seq(40, 0, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t3_conc_count", n_conc, 1);
        check("t3_ocupado_cycles", n_ocup, 40);
        check("t3_contagem", 32'(bus.contagem), 2);
        run_seq(1, 0, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t3_contagem_again", 32'(bus.contagem), 3);

        // 4: reset in the middle of suction
        bus.remover = 1'b1;
        tick();
        bus.remover = 1'b0;
        repeat (7) tick();
        check("t4_pre_succao", 32'(bus.succao), 1);
        reset = 1'b1;
        #1;
        check("t4_braco", 32'(bus.braco_desce), 0);
        check("t4_succao", 32'(bus.succao), 0);
        check("t4_ocupado", 32'(bus.ocupado), 0);
        check("t4_contagem", 32'(bus.contagem), 0);
        tick();
        reset = 1'b0;
        tick();
        run_seq(1, 0, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t4_conc_latency", conc_at, 16);
        check("t4_braco_cycles", n_braco, 12);
        check("t4_contagem_after", 32'(bus.contagem), 1);

        // 5: 2-bit counter saturates at 3
        for (int s = 1; s <= 5; s++) begin
            bus2.remover = 1'b1;
            tick();
            bus2.remover = 1'b0;
            repeat (20) tick();
            check($sformatf("t5_contagem_seq%0d", s), 32'(bus2.contagem), (s > 3) ? 3 : s);
        end

`ifdef REMOCAO_VERIFICA_EN
        // 6a: trash never leaves -> three attempts, failure, no count
        run_seq(1, 1000, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t6_succao_cycles", n_suc, 24);
        check("t6_braco_cycles", n_braco, 28);
        check("t6_conc_count", n_conc, 1);
        check("t6_conc_latency", conc_at, 32);
        check("t6_falha", 32'(bus.falha), 1);
        check("t6_contagem", 32'(bus.contagem), 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        // 6b: trash cleared during the second attempt
        run_seq(1, 14, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t6b_succao_cycles", n_suc, 16);
        check("t6b_conc_latency", conc_at, 24);
        check("t6b_falha", 32'(bus.falha), 0);
        check("t6b_contagem", 32'(bus.contagem), 1);
`else
        // 6: under is ignored without the re-check feature
        run_seq(1, 1000, n_braco, n_suc, n_conc, conc_at, n_ocup, cnt_at_conc);
        check("t6_succao_cycles", n_suc, 8);
        check("t6_conc_latency", conc_at, 16);
        check("t6_falha", 32'(bus.falha), 0);
        check("t6_contagem", 32'(bus.contagem), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
